magic_event_counter: RTL and testbench

//  Free-running WIDTH-bit up-counter with four strictly increasing "magic" milestones.

---
 rtl/magic_counter_pkg.sv | 23 ++
 rtl/magic_evt_fifo.sv | 68 ++++++
 rtl/magic_event_counter.sv | 125 ++++++++++++
 tb/tb_magic_event_counter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/magic_counter_pkg.sv
// Shared types and defaults for the magic-milestone event counter.
// Event tags travel through the event FIFO as 3-bit values.
package magic_counter_pkg;

    typedef enum logic [2:0] {
        EVT_M0   = 3'd0,
        EVT_M1   = 3'd1,
        EVT_M2   = 3'd2,
        EVT_M3   = 3'd3,
        EVT_WRAP = 3'd4
    } evt_id_e;

    localparam int PHASE_W = 3;
    localparam logic [PHASE_W-1:0] PHASE_MAX = 3'd4;

    localparam int          DEF_WIDTH     = 20;
    localparam int unsigned DEF_MAGIC0    = 123456;
    localparam int unsigned DEF_MAGIC1    = 234567;
    localparam int unsigned DEF_MAGIC2    = 345678;
    localparam int unsigned DEF_MAGIC3    = 456789;
    localparam int          DEF_EVT_DEPTH = 4;

endpackage

// File: rtl/magic_evt_fifo.sv
// Small synchronous FIFO for event tags; a write is visible at dout one cycle later.
// Simultaneous push and pop is legal when full and leaves occupancy unchanged.
module magic_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_q];

    // A push into a full FIFO is only accepted when a pop frees the slot this cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/magic_event_counter.sv
// Free-running up-counter that emits a tagged event on each magic milestone and on wrap.
// Events queue in a small FIFO; an event-generating step waits while that FIFO is full.
module magic_event_counter
    import magic_counter_pkg::*;
#(
    parameter int          WIDTH     = DEF_WIDTH,
    parameter int unsigned MAGIC0    = DEF_MAGIC0,
    parameter int unsigned MAGIC1    = DEF_MAGIC1,
    parameter int unsigned MAGIC2    = DEF_MAGIC2,
    parameter int unsigned MAGIC3    = DEF_MAGIC3,
    parameter int          EVT_DEPTH = DEF_EVT_DEPTH
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en,
    output logic [WIDTH-1:0]   count,
    output logic [PHASE_W-1:0] phase,
    output logic               stall,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [2:0]         evt_id
);

    localparam logic [WIDTH-1:0] M0 = WIDTH'(MAGIC0);
    localparam logic [WIDTH-1:0] M1 = WIDTH'(MAGIC1);
    localparam logic [WIDTH-1:0] M2 = WIDTH'(MAGIC2);
    localparam logic [WIDTH-1:0] M3 = WIDTH'(MAGIC3);

    logic [WIDTH-1:0]   count_q, count_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [WIDTH-1:0]   nxt;
    logic               evt_gen;
    evt_id_e            evt_tag;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;
    logic               inc;

    // Decode what the next step would produce; wrap wins because nxt==0 is never a milestone.
    always_comb begin
        nxt     = count_q + 1'b1;
        evt_gen = 1'b1;
        evt_tag = EVT_WRAP;
        if (count_q == '1) begin
            evt_tag = EVT_WRAP;
        end else if (nxt == M0) begin
            evt_tag = EVT_M0;
        end else if (nxt == M1) begin
            evt_tag = EVT_M1;
        end else if (nxt == M2) begin
            evt_tag = EVT_M2;
        end else if (nxt == M3) begin
            evt_tag = EVT_M3;
        end else begin
            evt_gen = 1'b0;
        end
    end

    // Handshake: the head event transfers on any cycle where evt_valid && evt_ready;
    // evt_id is stable while evt_valid is high and no transfer occurs.
    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign stall     = en && evt_gen && fifo_full && !pop;
    assign inc       = en && !stall;
    assign push      = inc && evt_gen;

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (inc) begin
            count_d = nxt;
            if (evt_gen) begin
                if (evt_tag == EVT_WRAP) begin
                    phase_d = '0;
                end else if (phase_q != PHASE_MAX) begin
                    phase_d = phase_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            phase_q <= '0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count = count_q;
    assign phase = phase_q;

    magic_evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .DW    (3)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (evt_tag),
        .pop     (pop),
        .dout    (evt_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef FORMAL
    a_m0_no_skip: assert property (@(posedge clock) disable iff (!reset_n)
        (count_q < M0) |=> (count_q <= M0));
    a_m1_no_skip: assert property (@(posedge clock) disable iff (!reset_n)
        (count_q < M1) |=> (count_q <= M1));
    a_m2_no_skip: assert property (@(posedge clock) disable iff (!reset_n)
        (count_q < M2) |=> (count_q <= M2));
    a_m3_no_skip: assert property (@(posedge clock) disable iff (!reset_n)
        (count_q < M3) |=> (count_q <= M3));
    a_monotonic: assert property (@(posedge clock) disable iff (!reset_n)
        (count_q != '1) |=> (count_q > $past(count_q) || count_q == $past(count_q)));
    a_wrap: assert property (@(posedge clock) disable iff (!reset_n)
        (count_q == '1 && inc) |=> (count_q == '0));
`endif

endmodule

// File: tb/tb_magic_event_counter.sv
// Bench for magic_event_counter in a small configuration (WIDTH=5, milestones 4/8/12/16, 2-entry FIFO).
// A reference model tracks count/phase and queues expected event tags for comparison on each pop.
module tb_magic_event_counter;

    localparam int W     = 5;
    localparam int DEPTH = 2;
    localparam int M0    = 4;
    localparam int M1    = 8;
    localparam int M2    = 12;
    localparam int M3    = 16;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         en;
    logic         evt_ready;
    logic [W-1:0] count;
    logic [2:0]   phase;
    logic         stall;
    logic         evt_valid;
    logic [2:0]   evt_id;

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0] exp_q[$];
    logic [2:0] pop_log[$];
    int         m_count;
    int         m_phase;

    always #5 clock = ~clock;

    magic_event_counter #(
        .WIDTH     (W),
        .MAGIC0    (M0),
        .MAGIC1    (M1),
        .MAGIC2    (M2),
        .MAGIC3    (M3),
        .EVT_DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .count     (count),
        .phase     (phase),
        .stall     (stall),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_count = 0;
        m_phase = 0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs at the negedge, check the settled outputs, advance the model.
    task automatic cycle(input logic en_i, input logic rdy_i);
        logic [W-1:0] nxt;
        logic [2:0]   tag;
        logic [2:0]   head;
        bit           gen;
        bit           pop;
        bit           full;
        bit           stl;
        bit           inc;
        en        = en_i;
        evt_ready = rdy_i;
        #1;
        pop  = (exp_q.size() != 0) && rdy_i;
        full = (exp_q.size() == DEPTH);
        nxt  = W'(m_count + 1);
        gen  = 1'b1;
        tag  = 3'd4;
        if (m_count == 31)    tag = 3'd4;
        else if (nxt == M0)   tag = 3'd0;
        else if (nxt == M1)   tag = 3'd1;
        else if (nxt == M2)   tag = 3'd2;
        else if (nxt == M3)   tag = 3'd3;
        else                  gen = 1'b0;
        stl = en_i && gen && full && !pop;
        inc = en_i && !stl;
        chk("count", 32'(count), 32'(m_count));
        chk("phase", 32'(phase), 32'(m_phase));
        chk("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
        chk("stall", 32'(stall), 32'(stl));
        if (pop) begin
            head = exp_q.pop_front();
            chk("evt_id", 32'(evt_id), 32'(head));
            pop_log.push_back(head);
        end
        if (inc) begin
            if (gen) begin
                exp_q.push_back(tag);
                if (tag == 3'd4)      m_phase = 0;
                else if (m_phase < 4) m_phase++;
            end
            m_count = int'(nxt);
        end
        @(negedge clock);
    endtask

    initial begin
        logic [2:0]   exp_tags [5];
        logic [W-1:0] prev;
        logic [W-1:0] delta;
        exp_tags = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

        // Reset held with en=1: nothing moves.
        reset_n   = 1'b0;
        en        = 1'b1;
        evt_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset_n = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0);
        chk("count_after_release", 32'(count), 32'd1);

        // Free running with a ready consumer: one full lap, every tag in order.
        pop_log.delete();
        repeat (34) cycle(1'b1, 1'b1);
        chk("lap_pop_count", 32'(pop_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < pop_log.size()) chk("lap_tag", 32'(pop_log[i]), 32'(exp_tags[i]));
        end
        chk("lap_count", 32'(count), 32'd3);
        chk("lap_phase", 32'(phase), 32'd0);

        // Consumer stalled: FIFO fills at 4 and 8, counting halts at 11.
        repeat (15) cycle(1'b1, 1'b0);
        chk("stall_count", 32'(count), 32'd11);
        chk("stall_flag", 32'(stall), 32'd1);

        // One-cycle ready while full: pop, push and increment in the same cycle.
        cycle(1'b1, 1'b1);
        chk("full_pop_count", 32'(count), 32'd12);
        chk("full_pop_valid", 32'(evt_valid), 32'd1);
        repeat (6) cycle(1'b1, 1'b0);
        chk("still_full_count", 32'(count), 32'd15);
        chk("still_full_stall", 32'(stall), 32'd1);

        // Asynchronous reset mid-cycle with two events queued.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_evt_valid", 32'(evt_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_phase", 32'(phase), 32'd0);
        chk("async_stall", 32'(stall), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();

        // Random enable and consumer: step of at most one, no milestone skipped.
        for (int i = 0; i < 300; i++) begin
            prev = count;
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            delta = count - prev;
            chk("step_le_1", 32'(delta <= 1), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
